timer_module_3ch: RTL and testbench

Three-channel 16-bit programmable down-counter timer, a Wishbone slave on the Amber system bus. It produces the three level-sensitive timer interrupts that feed the interrupt controller's `i_tm_timer_int[2:0]` (raw interrupt bits 5..7). Software programs each channel through load, value, control and clear registers. Each channel's interrupt stays asserted until software clears it.

---
 rtl/timer_module_3ch_pkg.sv | 50 +++++
 rtl/timer_module_3ch_channel.sv | 68 ++++++
 rtl/timer_module_3ch.sv | 89 ++++++++
 tb/tb_timer_module_3ch.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_module_3ch_pkg.sv
// rtl/timer_module_3ch_pkg.sv - register map, CTRL layout and prescaler helper (honours AMBER_TIMER_ONESHOT_EN)
package timer_module_3ch_pkg;

    localparam logic [15:0] AMBER_TM_TIMER0_LOAD  = 16'h0000;
    localparam logic [15:0] AMBER_TM_TIMER0_VALUE = 16'h0004;
    localparam logic [15:0] AMBER_TM_TIMER0_CTRL  = 16'h0008;
    localparam logic [15:0] AMBER_TM_TIMER0_CLR   = 16'h000C;
    localparam logic [15:0] AMBER_TM_TIMER1_LOAD  = 16'h0100;
    localparam logic [15:0] AMBER_TM_TIMER1_VALUE = 16'h0104;
    localparam logic [15:0] AMBER_TM_TIMER1_CTRL  = 16'h0108;
    localparam logic [15:0] AMBER_TM_TIMER1_CLR   = 16'h010C;
    localparam logic [15:0] AMBER_TM_TIMER2_LOAD  = 16'h0200;
    localparam logic [15:0] AMBER_TM_TIMER2_VALUE = 16'h0204;
    localparam logic [15:0] AMBER_TM_TIMER2_CTRL  = 16'h0208;
    localparam logic [15:0] AMBER_TM_TIMER2_CLR   = 16'h020C;

    localparam logic [31:0] AMBER_TM_UNMAPPED_RD = 32'h66778899;

    localparam int CTRL_ENABLE_BIT   = 7;
    localparam int CTRL_PERIODIC_BIT = 6;
    localparam int CTRL_ONESHOT_BIT  = 5;
    localparam int CTRL_PRESC_LSB    = 2;

`ifdef AMBER_TIMER_ONESHOT_EN
    localparam bit ONESHOT_EN = 1'b1;
`else
    localparam bit ONESHOT_EN = 1'b0;
`endif

    // Only these CTRL bits are stored; everything else reads back as 0.
    localparam logic [7:0] CTRL_WR_MASK = 8'((1 << CTRL_ENABLE_BIT) | (1 << CTRL_PERIODIC_BIT)
                                          | (3 << CTRL_PRESC_LSB)
                                          | (ONESHOT_EN ? (1 << CTRL_ONESHOT_BIT) : 0));

    typedef enum logic [1:0] {
        REG_LOAD  = 2'd0,
        REG_VALUE = 2'd1,
        REG_CTRL  = 2'd2,
        REG_CLR   = 2'd3
    } reg_off_e;

    function automatic logic presc_tick(input logic [1:0] sel, input logic [7:0] cnt);
        case (sel)
            2'b00:   return 1'b1;
            2'b01:   return &cnt[3:0];
            default: return &cnt;
        endcase
    endfunction

endpackage

// File: rtl/timer_module_3ch_channel.sv
// rtl/timer_module_3ch_channel.sv - one 16-bit down-counter channel (one-shot via AMBER_TIMER_ONESHOT_EN)
module timer_channel
    import timer_module_3ch_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        load_wr,
    input  logic        ctrl_wr,
    input  logic        clr_wr,
    input  logic [15:0] wr_dat,
    output logic [15:0] load,
    output logic [15:0] value,
    output logic [7:0]  ctrl,
    output logic        irq
);

    logic [7:0] presc;
    logic       enable;
    logic       periodic;
    logic       oneshot;
    logic       tick;
    logic       zero_tick;

    assign enable   = ctrl[CTRL_ENABLE_BIT];
    assign periodic = ctrl[CTRL_PERIODIC_BIT];
    // Never set when one-shot is not built, because the CTRL mask drops the bit.
    assign oneshot  = ctrl[CTRL_ONESHOT_BIT];

    // A LOAD write swallows any tick landing in the same cycle.
    assign tick      = enable && !load_wr && presc_tick(ctrl[CTRL_PRESC_LSB +: 2], presc);
    assign zero_tick = tick && (value == 16'd0);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            load  <= 16'd0;
            value <= 16'd0;
            ctrl  <= 8'd0;
            presc <= 8'd0;
            irq   <= 1'b0;
        end else begin
            if (load_wr) begin
                load  <= wr_dat;
                value <= wr_dat;
                presc <= 8'd0;
            end else begin
                if (enable)
                    presc <= presc + 8'd1;
                if (tick) begin
                    if (value != 16'd0)
                        value <= value - 16'd1;
                    else if (!oneshot)
                        value <= periodic ? load : 16'hFFFF;
                end
            end

            if (ctrl_wr)
                ctrl <= wr_dat[7:0] & CTRL_WR_MASK;
            else if (zero_tick && oneshot)
                ctrl[CTRL_ENABLE_BIT] <= 1'b0;

            if (zero_tick)
                irq <= 1'b1;
            else if (clr_wr)
                irq <= 1'b0;
        end
    end

endmodule

// File: rtl/timer_module_3ch.sv
// rtl/timer_module_3ch.sv - three-channel Wishbone timer: bus decode, read mux, channel instances
module timer_module_3ch
    import timer_module_3ch_pkg::*;
#(
    parameter int TIMERS = 3
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [31:0]       i_wb_adr,
    input  logic [3:0]        i_wb_sel,
    input  logic              i_wb_we,
    input  logic [31:0]       i_wb_dat,
    output logic [31:0]       o_wb_dat,
    input  logic              i_wb_cyc,
    input  logic              i_wb_stb,
    output logic              o_wb_ack,
    output logic              o_wb_err,
    output logic [TIMERS-1:0] o_timer_int
);

    logic        read_d1;
    logic        wr_en;
    logic        rd_start;
    logic        addr_hit;
    logic [1:0]  ch_idx;
    reg_off_e    reg_off;
    logic [31:0] rd_mux;
    logic [15:0] ch_load  [TIMERS];
    logic [15:0] ch_value [TIMERS];
    logic [7:0]  ch_ctrl  [TIMERS];

    logic unused_bus;
    assign unused_bus = &{1'b0, i_wb_sel, i_wb_cyc, i_wb_adr[31:16], i_wb_dat[31:16]};

    assign ch_idx   = i_wb_adr[9:8];
    assign reg_off  = reg_off_e'(i_wb_adr[3:2]);
    assign addr_hit = (i_wb_adr[15:10] == 6'd0) && (i_wb_adr[7:4] == 4'd0)
                   && (i_wb_adr[1:0] == 2'd0) && (int'(ch_idx) < TIMERS);

    // Writes ack combinationally; a pending read ack blocks them for that cycle.
    assign wr_en    = i_wb_stb & i_wb_we & ~read_d1;
    assign rd_start = i_wb_stb & ~i_wb_we & ~o_wb_ack;
    assign o_wb_ack = wr_en | read_d1;
    assign o_wb_err = 1'b0;

    for (genvar g = 0; g < TIMERS; g++) begin : g_ch
        logic sel;
        assign sel = wr_en && addr_hit && (ch_idx == 2'(g));

        timer_channel u_ch (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .load_wr (sel && (reg_off == REG_LOAD)),
            .ctrl_wr (sel && (reg_off == REG_CTRL)),
            .clr_wr  (sel && (reg_off == REG_CLR)),
            .wr_dat  (i_wb_dat[15:0]),
            .load    (ch_load[g]),
            .value   (ch_value[g]),
            .ctrl    (ch_ctrl[g]),
            .irq     (o_timer_int[g])
        );
    end

    always_comb begin
        rd_mux = AMBER_TM_UNMAPPED_RD;
        for (int i = 0; i < TIMERS; i++) begin
            if (addr_hit && (ch_idx == 2'(i))) begin
                case (reg_off)
                    REG_LOAD:  rd_mux = {16'd0, ch_load[i]};
                    REG_VALUE: rd_mux = {16'd0, ch_value[i]};
                    REG_CTRL:  rd_mux = {24'd0, ch_ctrl[i]};
                    REG_CLR:   rd_mux = 32'd0;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            read_d1  <= 1'b0;
            o_wb_dat <= 32'd0;
        end else begin
            read_d1 <= rd_start;
            if (rd_start)
                o_wb_dat <= rd_mux;
        end
    end

endmodule

// File: tb/tb_timer_module_3ch.sv
// tb/tb_timer_module_3ch.sv - directed self-checking bench for timer_module_3ch
module tb_timer_module_3ch;
    import timer_module_3ch_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [31:0] i_wb_adr = 32'd0;
    logic [3:0]  i_wb_sel = 4'hF;
    logic        i_wb_we = 1'b0;
    logic [31:0] i_wb_dat = 32'd0;
    logic [31:0] o_wb_dat;
    logic        i_wb_cyc = 1'b0;
    logic        i_wb_stb = 1'b0;
    logic        o_wb_ack;
    logic        o_wb_err;
    logic [2:0]  o_timer_int;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    int          wr_edge;
    logic        wr_ack;
    logic [31:0] rd_data;
    logic        rd_ack;
    logic        rd_ack_early;
    int          rise_edge;
    int          c0;

    timer_module_3ch #(.TIMERS(3)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_wb_adr    (i_wb_adr),
        .i_wb_sel    (i_wb_sel),
        .i_wb_we     (i_wb_we),
        .i_wb_dat    (i_wb_dat),
        .o_wb_dat    (o_wb_dat),
        .i_wb_cyc    (i_wb_cyc),
        .i_wb_stb    (i_wb_stb),
        .o_wb_ack    (o_wb_ack),
        .o_wb_err    (o_wb_err),
        .o_timer_int (o_timer_int)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    // Bus drivers: k is the clock edge (value of cyc after it) on which the access lands.
    task automatic bus_write(input int k, input logic [15:0] a, input logic [31:0] d);
        while (cyc < k - 1) @(negedge i_clk);
        i_wb_adr = {16'd0, a}; i_wb_dat = d; i_wb_we = 1'b1; i_wb_stb = 1'b1; i_wb_cyc = 1'b1;
        #1 wr_ack = o_wb_ack;
        @(posedge i_clk);
        #1 wr_edge = cyc;
        i_wb_stb = 1'b0; i_wb_we = 1'b0; i_wb_cyc = 1'b0;
    endtask

    task automatic bus_read(input int k, input logic [15:0] a);
        while (cyc < k - 1) @(negedge i_clk);
        i_wb_adr = {16'd0, a}; i_wb_we = 1'b0; i_wb_stb = 1'b1; i_wb_cyc = 1'b1;
        #1 rd_ack_early = o_wb_ack;
        @(posedge i_clk);
        #1 rd_ack = o_wb_ack;
        rd_data = o_wb_dat;
        i_wb_stb = 1'b0; i_wb_cyc = 1'b0;
        @(posedge i_clk);
        #1;
    endtask

    task automatic wait_rise(input int ch, input int bound);
        rise_edge = -1;
        for (int i = 0; i < bound; i++) begin
            @(posedge i_clk);
            #1;
            if (o_timer_int[ch]) begin
                rise_edge = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset;
        total++; if (o_timer_int !== 3'b000) begin bad++; $display("FAIL reset_int got=%b exp=000", o_timer_int); end
        total++; if (o_wb_ack !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b exp=0", o_wb_ack); end
        total++; if (o_wb_dat !== 32'd0) begin bad++; $display("FAIL reset_dat got=%h exp=0", o_wb_dat); end
        total++; if (o_wb_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", o_wb_err); end
        bus_read(cyc + 1, AMBER_TM_TIMER0_LOAD);
        total++; if (rd_data !== 32'd0) begin bad++; $display("FAIL reset_load0 got=%h exp=0", rd_data); end
        total++; if (rd_ack_early !== 1'b0 || rd_ack !== 1'b1) begin bad++; $display("FAIL reset_rd_ack got=%b%b exp=01", rd_ack_early, rd_ack); end
        bus_read(cyc + 1, AMBER_TM_TIMER1_CTRL);
        total++; if (rd_data !== 32'd0) begin bad++; $display("FAIL reset_ctrl1 got=%h exp=0", rd_data); end
        bus_read(cyc + 1, AMBER_TM_TIMER2_VALUE);
        total++; if (rd_data !== 32'd0) begin bad++; $display("FAIL reset_value2 got=%h exp=0", rd_data); end
        bus_read(cyc + 1, AMBER_TM_TIMER0_CLR);
        total++; if (rd_data !== 32'd0) begin bad++; $display("FAIL clr_reads_0 got=%h exp=0", rd_data); end
    endtask

    task automatic test_periodic;
        bus_write(cyc + 1, AMBER_TM_TIMER0_LOAD, 32'd4);
        bus_write(cyc + 1, AMBER_TM_TIMER0_CTRL, 32'hC0);
        c0 = wr_edge;
        total++; if (wr_ack !== 1'b1) begin bad++; $display("FAIL wr_ack got=%b exp=1", wr_ack); end
        wait_rise(0, 20);
        total++; if (rise_edge != c0 + 5) begin bad++; $display("FAIL periodic_first got=%0d exp=%0d", rise_edge, c0 + 5); end
        bus_write(cyc + 1, AMBER_TM_TIMER0_CLR, 32'd1);
        total++; if (o_timer_int[0] !== 1'b0) begin bad++; $display("FAIL periodic_clr got=%b exp=0", o_timer_int[0]); end
        wait_rise(0, 20);
        total++; if (rise_edge != c0 + 10) begin bad++; $display("FAIL periodic_second got=%0d exp=%0d", rise_edge, c0 + 10); end
    endtask

    task automatic test_clr_collision;
        bus_write(c0 + 12, AMBER_TM_TIMER0_CLR, 32'd1);
        total++; if (o_timer_int[0] !== 1'b0) begin bad++; $display("FAIL clr_plain got=%b exp=0", o_timer_int[0]); end
        bus_write(c0 + 15, AMBER_TM_TIMER0_CLR, 32'd1);
        total++; if (o_timer_int[0] !== 1'b1) begin bad++; $display("FAIL clr_vs_set got=%b exp=1", o_timer_int[0]); end
    endtask

    task automatic test_load_collision;
        bus_write(cyc + 1, AMBER_TM_TIMER0_LOAD, 32'd9);
        bus_read(cyc + 1, AMBER_TM_TIMER0_VALUE);
        total++; if (rd_data !== 32'd9) begin bad++; $display("FAIL load_vs_tick got=%h exp=9", rd_data); end
        bus_write(cyc + 1, AMBER_TM_TIMER0_CTRL, 32'h00);
        bus_write(cyc + 1, AMBER_TM_TIMER0_CLR, 32'd1);
        total++; if (o_timer_int !== 3'b000) begin bad++; $display("FAIL cleanup_int got=%b exp=000", o_timer_int); end
    endtask

    task automatic test_prescale16;
        int c;
        bus_write(cyc + 1, AMBER_TM_TIMER1_LOAD, 32'd2);
        bus_write(cyc + 1, AMBER_TM_TIMER1_CTRL, 32'hC4);
        c = wr_edge;
        bus_read(c + 8, AMBER_TM_TIMER1_VALUE);
        total++; if (rd_data !== 32'd2) begin bad++; $display("FAIL presc_val_a got=%h exp=2", rd_data); end
        bus_read(c + 24, AMBER_TM_TIMER1_VALUE);
        total++; if (rd_data !== 32'd1) begin bad++; $display("FAIL presc_val_b got=%h exp=1", rd_data); end
        bus_read(c + 40, AMBER_TM_TIMER1_VALUE);
        total++; if (rd_data !== 32'd0) begin bad++; $display("FAIL presc_val_c got=%h exp=0", rd_data); end
        wait_rise(1, 30);
        total++; if (rise_edge != c + 48) begin bad++; $display("FAIL presc_irq got=%0d exp=%0d", rise_edge, c + 48); end
        bus_read(cyc + 1, AMBER_TM_TIMER1_CTRL);
        total++; if (rd_data !== 32'hC4) begin bad++; $display("FAIL presc_ctrl got=%h exp=c4", rd_data); end
        bus_write(cyc + 1, AMBER_TM_TIMER1_CTRL, 32'h00);
        bus_write(cyc + 1, AMBER_TM_TIMER1_CLR, 32'd1);
    endtask

    task automatic test_ctrl_bits;
        logic [31:0] exp_ctrl;
`ifdef AMBER_TIMER_ONESHOT_EN
        exp_ctrl = 32'h6C;
`else
        exp_ctrl = 32'h4C;
`endif
        bus_write(cyc + 1, AMBER_TM_TIMER2_CTRL, 32'hFFFF_FF7F);
        bus_read(cyc + 1, AMBER_TM_TIMER2_CTRL);
        total++; if (rd_data !== exp_ctrl) begin bad++; $display("FAIL ctrl_mask got=%h exp=%h", rd_data, exp_ctrl); end
        bus_write(cyc + 1, AMBER_TM_TIMER2_CTRL, 32'h00);
        bus_write(cyc + 1, AMBER_TM_TIMER2_CLR, 32'd1);
    endtask

    task automatic test_freerun;
        int c;
        int d;
        logic [15:0] exp_v;
        bus_write(cyc + 1, AMBER_TM_TIMER2_LOAD, 32'd1);
        bus_write(cyc + 1, AMBER_TM_TIMER2_CTRL, 32'h80);
        c = wr_edge;
        wait_rise(2, 20);
        total++; if (rise_edge != c + 2) begin bad++; $display("FAIL free_irq got=%0d exp=%0d", rise_edge, c + 2); end
        bus_read(cyc + 1, AMBER_TM_TIMER2_VALUE);
        total++; if (rd_data !== 32'h0000FFFF) begin bad++; $display("FAIL free_wrap got=%h exp=ffff", rd_data); end
        bus_write(cyc + 1, AMBER_TM_TIMER2_CTRL, 32'h00);
        d = wr_edge;
        exp_v = 16'(32'hFFFF - (d - c - 2));
        repeat (5) @(posedge i_clk);
        bus_read(cyc + 1, AMBER_TM_TIMER2_VALUE);
        total++; if (rd_data !== {16'd0, exp_v}) begin bad++; $display("FAIL freeze got=%h exp=%h", rd_data, exp_v); end
    endtask

    task automatic test_unmapped;
        bus_read(cyc + 1, 16'h0400);
        total++; if (rd_data !== 32'h66778899) begin bad++; $display("FAIL unmapped_rd got=%h exp=66778899", rd_data); end
        total++; if (rd_ack_early !== 1'b0 || rd_ack !== 1'b1) begin bad++; $display("FAIL unmapped_ack got=%b%b exp=01", rd_ack_early, rd_ack); end
        bus_write(cyc + 1, 16'h0400, 32'd123);
        total++; if (wr_ack !== 1'b1) begin bad++; $display("FAIL unmapped_wr_ack got=%b exp=1", wr_ack); end
        bus_read(cyc + 1, AMBER_TM_TIMER0_LOAD);
        total++; if (rd_data !== 32'd9) begin bad++; $display("FAIL unmapped_wr_ignored got=%h exp=9", rd_data); end
    endtask

    task automatic test_reset_midcount;
        bus_write(cyc + 1, AMBER_TM_TIMER0_LOAD, 32'd100);
        bus_write(cyc + 1, AMBER_TM_TIMER0_CTRL, 32'hC0);
        repeat (3) @(posedge i_clk);
        #1;
        total++; if (o_timer_int !== 3'b100) begin bad++; $display("FAIL pre_reset_int got=%b exp=100", o_timer_int); end
        @(negedge i_clk);
        i_rst = 1'b1;
        #1;
        total++; if (o_timer_int !== 3'b000) begin bad++; $display("FAIL async_rst_int got=%b exp=000", o_timer_int); end
        total++; if (o_wb_dat !== 32'd0) begin bad++; $display("FAIL async_rst_dat got=%h exp=0", o_wb_dat); end
        @(negedge i_clk);
        i_rst = 1'b0;
        bus_read(cyc + 1, AMBER_TM_TIMER0_VALUE);
        total++; if (rd_data !== 32'd0) begin bad++; $display("FAIL rst_value0 got=%h exp=0", rd_data); end
        bus_read(cyc + 1, AMBER_TM_TIMER0_CTRL);
        total++; if (rd_data !== 32'd0) begin bad++; $display("FAIL rst_ctrl0 got=%h exp=0", rd_data); end
    endtask

`ifdef AMBER_TIMER_ONESHOT_EN
    task automatic test_oneshot;
        int c;
        bus_write(cyc + 1, AMBER_TM_TIMER0_LOAD, 32'd3);
        bus_write(cyc + 1, AMBER_TM_TIMER0_CTRL, 32'hE0);
        c = wr_edge;
        wait_rise(0, 20);
        total++; if (rise_edge != c + 4) begin bad++; $display("FAIL oneshot_irq got=%0d exp=%0d", rise_edge, c + 4); end
        bus_read(cyc + 1, AMBER_TM_TIMER0_CTRL);
        total++; if (rd_data !== 32'h60) begin bad++; $display("FAIL oneshot_ctrl got=%h exp=60", rd_data); end
        bus_read(cyc + 1, AMBER_TM_TIMER0_VALUE);
        total++; if (rd_data !== 32'd0) begin bad++; $display("FAIL oneshot_value got=%h exp=0", rd_data); end
        bus_write(cyc + 1, AMBER_TM_TIMER0_CLR, 32'd1);
        repeat (10) @(posedge i_clk);
        #1;
        total++; if (o_timer_int[0] !== 1'b0) begin bad++; $display("FAIL oneshot_single got=%b exp=0", o_timer_int[0]); end
    endtask
`endif

    initial begin
        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;
        test_reset;
        test_periodic;
        test_clr_collision;
        test_load_collision;
        test_prescale16;
        test_ctrl_bits;
        test_freerun;
        test_unmapped;
        test_reset_midcount;
`ifdef AMBER_TIMER_ONESHOT_EN
        test_oneshot;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d exp=finished", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
